// File: rtl/cpu_control_mc.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// request/ready memory handshake, a memory timeout and a trap state.
module cpu_control_mc #(
    parameter int BYTE_LANES  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           IR,
    input  logic                  overflow,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_load,
    output logic                  pc_write,
    output logic                  Jump,
    output logic                  Ex_top,
    output logic                  Shift_amounsrc,
    output logic                  Regdst,
    output logic                  ALU_shift_sel,
    output logic                  Regdto,
    output logic [1:0]            Shift_op,
    output logic [1:0]            ALU_srcB,
    output logic [2:0]            condition,
    output logic [3:0]            ALU_op,
    output logic [BYTE_LANES-1:0] Rd_write_byte_en,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // sel packs {Regdto, ALU_shift_sel, Regdst, Jump}
    typedef struct packed {
        logic       legal;
        logic       is_j;
        logic       is_bgez;
        logic       is_lw;
        logic       is_sw;
        logic       ovf_chk;
        logic [3:0] alu_op;
        logic [3:0] sel;
        logic [1:0] shift_op;
        logic       shift_amt_src;
        logic [1:0] srcb;
        logic       ex_top;
        logic [2:0] cond;
    } dec_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] trap_cause_q, trap_cause_d;
    dec_t       dec;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir_bits;

    assign opcode         = IR[31:26];
    assign funct          = IR[5:0];
    assign unused_ir_bits = ^IR[25:6];

    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin dec.alu_op = 4'b1110; dec.sel = 4'b0010; dec.ovf_chk = 1'b1; end
                    6'b100010: begin dec.alu_op = 4'b1111; dec.sel = 4'b0010; dec.ovf_chk = 1'b1; end
                    6'b100011: begin dec.alu_op = 4'b0001; dec.sel = 4'b0010; end
                    6'b000111: begin
                        dec.alu_op        = 4'b0001;
                        dec.sel           = 4'b0110;
                        dec.shift_op      = 2'b10;
                        dec.shift_amt_src = 1'b1;
                    end
                    6'b000010: begin dec.alu_op = 4'b0001; dec.sel = 4'b0010; dec.shift_op = 2'b11; end
                    6'b101011: begin dec.alu_op = 4'b0111; dec.sel = 4'b0010; end
                    default:   dec.legal = 1'b0;
                endcase
            end
            6'b001000: begin
                dec.alu_op  = 4'b1110;
                dec.sel     = 4'b1000;
                dec.srcb    = 2'b01;
                dec.ex_top  = 1'b1;
                dec.ovf_chk = 1'b1;
            end
            6'b001001: dec.srcb = 2'b01;
            6'b001110: begin dec.alu_op = 4'b1001; dec.sel = 4'b1000; dec.srcb = 2'b01; end
            6'b001010: begin dec.alu_op = 4'b0101; dec.sel = 4'b1000; dec.srcb = 2'b01; end
            6'b001111: begin dec.sel = 4'b1000; dec.srcb = 2'b10; end
            6'b011100: begin
                case (funct)
                    6'b100001: begin dec.alu_op = 4'b0011; dec.sel = 4'b1010; end
                    6'b100000: begin dec.alu_op = 4'b0010; dec.sel = 4'b1010; end
                    default:   dec.legal = 1'b0;
                endcase
            end
            6'b011111: begin
                if (funct == 6'b100000) begin
                    dec.alu_op = 4'b1010;
                    dec.sel    = 4'b0010;
                end else begin
                    dec.legal = 1'b0;
                end
            end
            6'b000010: begin dec.is_j = 1'b1; dec.sel = 4'b0001; end
            6'b000001: begin dec.is_bgez = 1'b1; dec.cond = 3'b011; dec.alu_op = 4'b0001; end
            6'b100011: begin dec.is_lw = 1'b1; dec.srcb = 2'b01; dec.ex_top = 1'b1; end
            6'b101011: begin dec.is_sw = 1'b1; dec.srcb = 2'b01; dec.ex_top = 1'b1; end
            default:   dec.legal = 1'b0;
        endcase
    end

    // The wait counter only advances while a request is outstanding, so any
    // state change leaves it cleared for the next FETCH or MEM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        trap_cause_d = trap_cause_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else if (dec.is_lw)     state_d = S_WB;
                    else                    state_d = S_FETCH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!dec.legal) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec.is_j || dec.is_bgez)      state_d = S_FETCH;
                else if (dec.is_lw || dec.is_sw)  state_d = S_MEM;
                else if (dec.ovf_chk && overflow) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b01;
                end else                          state_d = S_WB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            cnt_q        <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Outputs are held at zero while rst is high so an abort never commits a
    // write, PC update or memory request on the reset edge.
    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        ir_load          = 1'b0;
        pc_write         = 1'b0;
        trap             = 1'b0;
        Rd_write_byte_en = '0;
        {Regdto, ALU_shift_sel, Regdst, Jump} = 4'b0000;
        Ex_top           = 1'b0;
        Shift_amounsrc   = 1'b0;
        Shift_op         = 2'b00;
        ALU_srcB         = 2'b00;
        condition        = 3'b000;
        ALU_op           = 4'b0000;
        if (!rst) begin
            if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
                {Regdto, ALU_shift_sel, Regdst, Jump} = dec.sel;
                Ex_top         = dec.ex_top;
                Shift_amounsrc = dec.shift_amt_src;
                Shift_op       = dec.shift_op;
                ALU_srcB       = dec.srcb;
                condition      = dec.cond;
                ALU_op         = dec.alu_op;
            end
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_load  = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC:  pc_write = dec.is_j | dec.is_bgez;
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = dec.is_sw;
                end
                S_WB: begin
                    Rd_write_byte_en = '1;
                    if (dec.is_lw) begin
                        Regdto = 1'b1;
                        Regdst = 1'b0;
                    end
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign trap_cause = rst ? 2'b00 : trap_cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_control_mc.sv
// Directed vector bench for cpu_control_mc: per-cycle table of inputs and
// expected outputs, plus hand-written timeout and reset-abort sequences.
module tb_cpu_control_mc;

    localparam int LANES = 4;
    localparam int TMO   = 16;

    localparam logic [31:0] I_ADDIU = 32'h2441_0005;
    localparam logic [31:0] I_ADD   = 32'h0022_1820;
    localparam logic [31:0] I_LW    = 32'h8C22_0004;
    localparam logic [31:0] I_SW    = 32'hAC22_0004;
    localparam logic [31:0] I_ILL   = 32'hFC00_0000;
    localparam logic [31:0] I_RBAD  = 32'h0022_1824;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_BGEZ  = 32'h0421_0008;
    localparam logic [31:0] I_ADDI  = 32'h2022_0001;
    localparam logic [31:0] I_SRAV  = 32'h0022_1807;
    localparam logic [31:0] I_ROTR  = 32'h0022_1902;
    localparam logic [31:0] I_CLO   = 32'h7020_1821;
    localparam logic [31:0] I_SEB   = 32'h7C02_1C20;
    localparam logic [31:0] I_LUI   = 32'h3C01_0010;

    // {Regdto,ALU_shift_sel,Regdst,Jump, Ex_top, Shift_amounsrc, Shift_op, ALU_srcB, condition, ALU_op}
    localparam logic [16:0] DP_NONE  = '0;
    localparam logic [16:0] DP_ADDIU = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 4'b0000};
    localparam logic [16:0] DP_ADD   = {4'b0010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 4'b1110};
    localparam logic [16:0] DP_LW    = {4'b0000, 1'b1, 1'b0, 2'b00, 2'b01, 3'b000, 4'b0000};
    localparam logic [16:0] DP_LWWB  = {4'b1000, 1'b1, 1'b0, 2'b00, 2'b01, 3'b000, 4'b0000};
    localparam logic [16:0] DP_J     = {4'b0001, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 4'b0000};
    localparam logic [16:0] DP_BGEZ  = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b011, 4'b0001};
    localparam logic [16:0] DP_ADDI  = {4'b1000, 1'b1, 1'b0, 2'b00, 2'b01, 3'b000, 4'b1110};
    localparam logic [16:0] DP_SRAV  = {4'b0110, 1'b0, 1'b1, 2'b10, 2'b00, 3'b000, 4'b0001};
    localparam logic [16:0] DP_ROTR  = {4'b0010, 1'b0, 1'b0, 2'b11, 2'b00, 3'b000, 4'b0001};
    localparam logic [16:0] DP_CLO   = {4'b1010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 4'b0011};
    localparam logic [16:0] DP_SEB   = {4'b0010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 4'b1010};
    localparam logic [16:0] DP_LUI   = {4'b1000, 1'b0, 1'b0, 2'b00, 2'b10, 3'b000, 4'b0000};

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      IR;
    logic             overflow;
    logic             mem_ready;
    logic             mem_req, mem_we, ir_load, pc_write;
    logic             Jump, Ex_top, Shift_amounsrc, Regdst, ALU_shift_sel, Regdto;
    logic [1:0]       Shift_op, ALU_srcB;
    logic [2:0]       condition;
    logic [3:0]       ALU_op;
    logic [LANES-1:0] Rd_write_byte_en;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state;

    always #5 clk = ~clk;

    cpu_control_mc #(.BYTE_LANES(LANES), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .IR(IR), .overflow(overflow), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .pc_write(pc_write),
        .Jump(Jump), .Ex_top(Ex_top), .Shift_amounsrc(Shift_amounsrc), .Regdst(Regdst),
        .ALU_shift_sel(ALU_shift_sel), .Regdto(Regdto), .Shift_op(Shift_op),
        .ALU_srcB(ALU_srcB), .condition(condition), .ALU_op(ALU_op),
        .Rd_write_byte_en(Rd_write_byte_en), .trap(trap), .trap_cause(trap_cause),
        .state(state)
    );

    // bus packs {mem_req, mem_we, ir_load, pc_write}
    typedef struct packed {
        logic        rst;
        logic [31:0] ir;
        logic        rdy;
        logic        ovf;
        logic [2:0]  st;
        logic [3:0]  bus;
        logic        tr;
        logic [1:0]  cs;
        logic [3:0]  we;
        logic [16:0] dp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void v(input logic r, input logic [31:0] ir, input logic rdy,
                              input logic ovf, input logic [2:0] st, input logic [3:0] bus,
                              input logic tr, input logic [1:0] cs, input logic [3:0] we,
                              input logic [16:0] dp);
        vec_t t;
        t = '{rst: r, ir: ir, rdy: rdy, ovf: ovf, st: st, bus: bus, tr: tr, cs: cs, we: we, dp: dp};
        vecs.push_back(t);
    endfunction

    // One full zero-wait ALU instruction: FETCH, DECODE, EXEC, WB.
    function automatic void alu4(input logic [31:0] ir, input logic ovf,
                                 input logic [16:0] dp, input logic [1:0] cs);
        v(1'b0, ir, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, cs, 4'h0, DP_NONE);
        v(1'b0, ir, 1'b1, 1'b0, 3'd1, 4'b0000, 1'b0, cs, 4'h0, DP_NONE);
        v(1'b0, ir, 1'b0, ovf,  3'd2, 4'b0000, 1'b0, cs, 4'h0, dp);
        v(1'b0, ir, 1'b0, 1'b0, 3'd4, 4'b0000, 1'b0, cs, 4'hF, dp);
    endfunction

    task automatic applyStimulus(input logic r, input logic [31:0] ir,
                                 input logic rdy, input logic ovf);
        @(posedge clk);
        #1;
        rst       = r;
        IR        = ir;
        mem_ready = rdy;
        overflow  = ovf;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] st, input logic [3:0] bus,
                               input logic tr, input logic [1:0] cs, input logic [3:0] we,
                               input logic [16:0] dp);
        logic [30:0] got, exp;
        got = {state, mem_req, mem_we, ir_load, pc_write, trap, trap_cause, Rd_write_byte_en,
               Regdto, ALU_shift_sel, Regdst, Jump, Ex_top, Shift_amounsrc, Shift_op,
               ALU_srcB, condition, ALU_op};
        exp = {st, bus, tr, cs, we, dp};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d bus=%b trap=%b cause=%b we=%b dp=%b, expected state=%0d bus=%b trap=%b cause=%b we=%b dp=%b",
                     name, got[30:28], got[27:24], got[23], got[22:21], got[20:17], got[16:0],
                     st, bus, tr, cs, we, dp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        IR        = '0;
        mem_ready = 1'b0;
        overflow  = 1'b0;

        v(1'b1, I_ADDIU, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 2'b00, 4'h0, DP_NONE);
        alu4(I_ADDIU, 1'b0, DP_ADDIU, 2'b00);
        // add with overflow traps from EXEC, no writeback
        v(1'b0, I_ADD, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b00, 4'h0, DP_NONE);
        v(1'b0, I_ADD, 1'b1, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b00, 4'h0, DP_NONE);
        v(1'b0, I_ADD, 1'b0, 1'b1, 3'd2, 4'b0000, 1'b0, 2'b00, 4'h0, DP_ADD);
        v(1'b0, I_ADD, 1'b0, 1'b0, 3'd5, 4'b0000, 1'b1, 2'b01, 4'h0, DP_NONE);
        v(1'b0, I_LW,  1'b0, 1'b0, 3'd0, 4'b1000, 1'b0, 2'b01, 4'h0, DP_NONE);
        // lw with three MEM wait cycles
        v(1'b0, I_LW, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b01, 4'h0, DP_NONE);
        v(1'b0, I_LW, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b01, 4'h0, DP_NONE);
        v(1'b0, I_LW, 1'b0, 1'b0, 3'd2, 4'b0000, 1'b0, 2'b01, 4'h0, DP_LW);
        for (int k = 0; k < 3; k++)
            v(1'b0, I_LW, 1'b0, 1'b0, 3'd3, 4'b1000, 1'b0, 2'b01, 4'h0, DP_LW);
        v(1'b0, I_LW, 1'b1, 1'b0, 3'd3, 4'b1000, 1'b0, 2'b01, 4'h0, DP_LW);
        v(1'b0, I_LW, 1'b0, 1'b0, 3'd4, 4'b0000, 1'b0, 2'b01, 4'hF, DP_LWWB);
        // illegal opcode
        v(1'b0, I_ILL, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b01, 4'h0, DP_NONE);
        v(1'b0, I_ILL, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b01, 4'h0, DP_NONE);
        v(1'b0, I_ILL, 1'b0, 1'b0, 3'd5, 4'b0000, 1'b1, 2'b10, 4'h0, DP_NONE);
        // j and bgez
        v(1'b0, I_J, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_J, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_J, 1'b0, 1'b0, 3'd2, 4'b0001, 1'b0, 2'b10, 4'h0, DP_J);
        v(1'b0, I_BGEZ, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_BGEZ, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_BGEZ, 1'b0, 1'b0, 3'd2, 4'b0001, 1'b0, 2'b10, 4'h0, DP_BGEZ);
        // zero-wait sw
        v(1'b0, I_SW, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_SW, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_SW, 1'b0, 1'b0, 3'd2, 4'b0000, 1'b0, 2'b10, 4'h0, DP_LW);
        v(1'b0, I_SW, 1'b1, 1'b0, 3'd3, 4'b1100, 1'b0, 2'b10, 4'h0, DP_LW);
        // R-type with an unknown funct
        v(1'b0, I_RBAD, 1'b1, 1'b0, 3'd0, 4'b1011, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_RBAD, 1'b0, 1'b0, 3'd1, 4'b0000, 1'b0, 2'b10, 4'h0, DP_NONE);
        v(1'b0, I_RBAD, 1'b0, 1'b0, 3'd5, 4'b0000, 1'b1, 2'b10, 4'h0, DP_NONE);
        alu4(I_ADDI, 1'b0, DP_ADDI, 2'b10);
        alu4(I_SRAV, 1'b1, DP_SRAV, 2'b10);
        alu4(I_ROTR, 1'b0, DP_ROTR, 2'b10);
        alu4(I_CLO,  1'b0, DP_CLO,  2'b10);
        alu4(I_SEB,  1'b0, DP_SEB,  2'b10);
        alu4(I_LUI,  1'b0, DP_LUI,  2'b10);

        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ir, vecs[i].rdy, vecs[i].ovf);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].bus, vecs[i].tr,
                        vecs[i].cs, vecs[i].we, vecs[i].dp);
        end

        // sw never acknowledged: exactly TMO request cycles, then timeout trap
        applyStimulus(1'b0, I_SW, 1'b1, 1'b0);
        checkOutput("swto_fetch", 3'd0, 4'b1011, 1'b0, 2'b10, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("swto_decode", 3'd1, 4'b0000, 1'b0, 2'b10, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("swto_exec", 3'd2, 4'b0000, 1'b0, 2'b10, 4'h0, DP_LW);
        for (int i = 0; i < TMO; i++) begin
            applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
            checkOutput($sformatf("swto_mem%0d", i), 3'd3, 4'b1100, 1'b0, 2'b10, 4'h0, DP_LW);
        end
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("swto_trap", 3'd5, 4'b0000, 1'b1, 2'b11, 4'h0, DP_NONE);

        // lw acknowledged on the last allowed cycle: ready beats the timeout
        applyStimulus(1'b0, I_LW, 1'b1, 1'b0);
        checkOutput("lwedge_fetch", 3'd0, 4'b1011, 1'b0, 2'b11, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_LW, 1'b0, 1'b0);
        checkOutput("lwedge_decode", 3'd1, 4'b0000, 1'b0, 2'b11, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_LW, 1'b0, 1'b0);
        checkOutput("lwedge_exec", 3'd2, 4'b0000, 1'b0, 2'b11, 4'h0, DP_LW);
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus(1'b0, I_LW, 1'b0, 1'b0);
            checkOutput($sformatf("lwedge_mem%0d", i), 3'd3, 4'b1000, 1'b0, 2'b11, 4'h0, DP_LW);
        end
        applyStimulus(1'b0, I_LW, 1'b1, 1'b0);
        checkOutput("lwedge_mem_last", 3'd3, 4'b1000, 1'b0, 2'b11, 4'h0, DP_LW);
        applyStimulus(1'b0, I_LW, 1'b0, 1'b0);
        checkOutput("lwedge_wb", 3'd4, 4'b0000, 1'b0, 2'b11, 4'hF, DP_LWWB);

        // reset in the middle of an sw MEM phase
        applyStimulus(1'b0, I_SW, 1'b1, 1'b0);
        checkOutput("rst_sw_fetch", 3'd0, 4'b1011, 1'b0, 2'b11, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("rst_sw_decode", 3'd1, 4'b0000, 1'b0, 2'b11, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("rst_sw_exec", 3'd2, 4'b0000, 1'b0, 2'b11, 4'h0, DP_LW);
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("rst_sw_mem", 3'd3, 4'b1100, 1'b0, 2'b11, 4'h0, DP_LW);
        applyStimulus(1'b1, I_SW, 1'b1, 1'b0);
        checkOutput("rst_in_mem", 3'd3, 4'b0000, 1'b0, 2'b00, 4'h0, DP_NONE);
        applyStimulus(1'b1, I_SW, 1'b0, 1'b0);
        checkOutput("rst_hold", 3'd0, 4'b0000, 1'b0, 2'b00, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("post_rst_fetch", 3'd0, 4'b1000, 1'b0, 2'b00, 4'h0, DP_NONE);

        // fetch never acknowledged also times out
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
            checkOutput($sformatf("fetch_wait%0d", i), 3'd0, 4'b1000, 1'b0, 2'b00, 4'h0, DP_NONE);
        end
        applyStimulus(1'b0, I_SW, 1'b0, 1'b0);
        checkOutput("fetch_to_trap", 3'd5, 4'b0000, 1'b1, 2'b11, 4'h0, DP_NONE);
        applyStimulus(1'b0, I_ADDIU, 1'b0, 1'b0);
        checkOutput("after_trap_fetch", 3'd0, 4'b1000, 1'b0, 2'b11, 4'h0, DP_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
